// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table characterizer.
package tt_pkg;

  localparam int IDX_W      = 3;
  localparam int NUM_COMBOS = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts cycles while enabled and flags the last settle cycle.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  // Count up to the terminal value and hold there so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_characterizer.sv
// Sweeps all 3-bit input combinations into a combinational target and
// captures its response as an 8-bit truth-table code.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start, drive_in parked at 0
// DRIVE  | driving combination idx, waiting SETTLE_CYCLES cycles
// SAMPLE | capture target_out into tt_code[7-idx], advance or finish
// DONE   | one-cycle done pulse; start here chains straight into a sweep
module tt_characterizer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED_CODE = 8'h78
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] drive_in,
  input  logic       target_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_code,
  output logic       match
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);

  tt_state_e        state;
  tt_state_e        state_nxt;
  logic [IDX_W-1:0] idx;
  logic             settle_tc;
  logic             sweep_go;
  logic             last_combo;
  logic [7:0]       code_nxt;

  assign last_combo = (idx == LAST_IDX);
  assign busy       = (state == DRIVE) || (state == SAMPLE);
  assign done       = (state == DONE);
  assign drive_in   = busy ? idx : '0;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != DRIVE),
    .enable(state == DRIVE),
    .tc    (settle_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    sweep_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sweep_go  = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_tc) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        state_nxt = last_combo ? DONE : DRIVE;
      end
      DONE: begin
        if (start) begin
          sweep_go  = 1'b1;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Truth-table code with the current response merged in at bit (7-idx).
  always_comb begin
    code_nxt                  = tt_code;
    code_nxt[LAST_IDX - idx]  = target_out;
  end

  // Sweep datapath: index, captured code and match flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      tt_code <= '0;
      match   <= 1'b0;
    end else if (sweep_go) begin
      idx     <= '0;
      tt_code <= '0;
      match   <= 1'b0;
    end else if (state == SAMPLE) begin
      tt_code <= code_nxt;
      if (last_combo) begin
        match <= (code_nxt == EXPECTED_CODE);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_characterizer.sv
// Directed and randomized sweeps of tt_characterizer against simple target models.
module tb_tt_characterizer;

  localparam int         S   = 4;
  localparam logic [7:0] EXP = 8'h78;
  localparam int         LAT = 8 * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] drive_in;
  logic       target_out;
  logic       busy;
  logic       done;
  logic [7:0] tt_code;
  logic       match;

  int         mode;
  logic [7:0] rnd_tt;
  int         n_assert = 0;
  int         n_fail   = 0;

  tt_characterizer #(
    .SETTLE_CYCLES(S),
    .EXPECTED_CODE(EXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .drive_in  (drive_in),
    .target_out(target_out),
    .busy      (busy),
    .done      (done),
    .tt_code   (tt_code),
    .match     (match)
  );

  always #5 clk = ~clk;

  // Target behaviours: 0 = reference (1 for inputs 1..4), 1 = stuck 0,
  // 2 = inverted reference, 3 = arbitrary table.
  function automatic logic tgt_fn(input int m, input int x, input logic [7:0] tbl);
    logic r;
    case (m)
      0:       r = (x >= 1 && x <= 4);
      1:       r = 1'b0;
      2:       r = !(x >= 1 && x <= 4);
      default: r = tbl[7 - x];
    endcase
    return r;
  endfunction

  function automatic logic [7:0] model_code(input int m, input logic [7:0] tbl);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[7 - i] = tgt_fn(m, i, tbl);
    return c;
  endfunction

  always_comb target_out = tgt_fn(mode, int'(drive_in), rnd_tt);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_chk(input string tag, input logic [7:0] code, input logic m);
    chk({tag, "_busy"},  8'(busy), 8'h00);
    chk({tag, "_done"},  8'(done), 8'h00);
    chk({tag, "_drive"}, 8'(drive_in), 8'h00);
    chk({tag, "_code"},  tt_code, code);
    chk({tag, "_match"}, 8'(match), 8'(m));
  endtask

  // Called in the cycle where start should be seen; returns in the done
  // cycle (or in the abort cycle with rst and start raised).
  task automatic sweep(input int m, input bit hold, input int rp1, input int rp2,
                       input int abort_at);
    logic [7:0] expc;
    logic [7:0] msk;
    int         n;
    mode  = m;
    expc  = model_code(m, rnd_tt);
    start = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      start = hold || (c == rp1) || (c == rp2);
      if (c < LAT) begin
        n   = (c - 1) / (S + 1);
        msk = (n == 0) ? 8'h00 : ~(8'hFF >> n);
        chk("sw_busy",  8'(busy), 8'h01);
        chk("sw_done",  8'(done), 8'h00);
        chk("sw_drive", 8'(drive_in), 8'(n));
        chk("sw_partial_code", tt_code, expc & msk);
      end else begin
        chk("fin_done",  8'(done), 8'h01);
        chk("fin_busy",  8'(busy), 8'h00);
        chk("fin_code",  tt_code, expc);
        chk("fin_match", 8'(match), 8'(expc == EXP));
      end
      if (c == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] last_code;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 0;
    rnd_tt = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    idle_chk("reset", 8'h00, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference target.
    sweep(0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    idle_chk("ref_after", 8'h78, 1'b1);

    // Stuck-at-0 target.
    sweep(1, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    idle_chk("zero_after", 8'h00, 1'b0);

    // Inverted reference target.
    sweep(2, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    idle_chk("inv_after", 8'h87, 1'b0);

    // Start re-pulsed while busy must be ignored.
    sweep(0, 1'b0, 10, 20, 0);
    @(posedge clk); #1;
    idle_chk("repulse_after", 8'h78, 1'b1);

    // Reset mid-sweep at idx 3, with start in the same cycle.
    sweep(0, 1'b0, 0, 0, 17);
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    idle_chk("abort", 8'h00, 1'b0);
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 8'(done), 8'h00);
      chk("abort_no_busy", 8'(busy), 8'h00);
    end
    sweep(0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    idle_chk("abort_rerun", 8'h78, 1'b1);

    // Start held through DONE chains a second sweep immediately.
    sweep(0, 1'b1, 0, 0, 0);
    sweep(0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    idle_chk("chain_after", 8'h78, 1'b1);

    // Random target tables with random ignored start pulses.
    for (int k = 0; k < 4; k++) begin
      rnd_tt = 8'($urandom);
      if (k == 0) rnd_tt = EXP;
      sweep(3, 1'b0, int'($urandom_range(1, LAT - 1)), int'($urandom_range(1, LAT - 1)), 0);
      last_code = model_code(3, rnd_tt);
      @(posedge clk); #1;
      idle_chk("rand_after", last_code, last_code == EXP);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
